key_filter_bank: RTL and testbench

Parametrised multi-channel push-button conditioner with long-press and auto-repeat detection. Each of `KEY_NUM` active-low mechanical key inputs is synchronised, debounced and edge-qualified independently. Each channel produces the classic press/release flag and debounced state, plus long-press and repeat pulses. The block sits between board pins and control logic such as the uart_scope menu/trigger controls, and replaces per-key single-channel filters.

---
 rtl/key_filter_pkg.sv | 30 +++
 rtl/key_filter_ch.sv | 186 ++++++++++++++++++
 rtl/key_filter_bank.sv | 56 +++++
 tb/tb_key_filter_bank.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// ---------------------------------------------------------------------------
// key_filter_pkg
// Shared definitions for the key filter bank.
//   key_st_e : per-channel FSM state encoding (2 bits)
//   cnt_w()  : width of a counter that must hold values 0..limit
// ---------------------------------------------------------------------------
package key_filter_pkg;

  // Per-channel conditioner state.
  //   ST_IDLE    : accepted released, input stable high
  //   ST_FILT_DN : candidate press, counting stable-low cycles
  //   ST_DOWN    : accepted pressed, hold/repeat timing active
  //   ST_FILT_UP : candidate release, counting stable-high cycles
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILT_DN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_FILT_UP = 2'd3
  } key_st_e;

  // Counter width able to represent 0..limit. A zero limit still gets one
  // bit so that disabled features keep a legal (unused) register.
  function automatic int cnt_w(input int unsigned limit);
    if (limit == 0) begin
      return 1;
    end
    return $clog2(limit + 1);
  endfunction

endpackage : key_filter_pkg

// File: rtl/key_filter_ch.sv
// ---------------------------------------------------------------------------
// key_filter_ch
// One push-button conditioner channel: 2-FF synchroniser, edge detector,
// debounce FSM, hold timer (long press) and auto-repeat timer.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-low reset
//   key_in    : raw key level, asynchronous (1 = released, 0 = pressed)
//   key_flag  : one-cycle pulse on each accepted press or release
//   key_state : debounced level (1 = released, 0 = pressed)
//   key_long  : one-cycle pulse when the hold time reaches LONG_CYCLES
//   key_rpt   : one-cycle pulse every REPEAT_CYCLES after key_long
//   dbg_state : current FSM state
// ---------------------------------------------------------------------------
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    key_in,
  output logic    key_flag,
  output logic    key_state,
  output logic    key_long,
  output logic    key_rpt,
  output key_st_e dbg_state
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w(LONG_CYCLES);
  localparam int RW = cnt_w(REPEAT_CYCLES);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  // The hold counter parks at LONG_CYCLES once key_long has fired; that
  // saturated value doubles as the "long press already reported" marker.
  localparam logic [HW-1:0] LONG_SAT  = HW'(LONG_CYCLES);
  localparam logic [RW-1:0] RPT_LAST  =
    RW'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);

  // Synchroniser and edge-detect registers (reset to the released level).
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // FSM and counters.
  key_st_e         state_q, state_d;
  logic [DW-1:0]   db_q,    db_d;
  logic [HW-1:0]   hold_q,  hold_d;
  logic [RW-1:0]   rep_q,   rep_d;

  // Registered outputs.
  logic flag_q,      flag_d;
  logic key_state_q, key_state_d;
  logic long_q,      long_d;
  logic rpt_q,       rpt_d;

  logic lvl;
  logic fall;
  logic rise;

  // The FSM only ever looks at the synchronised level and its edges.
  assign lvl  = sync2_q;
  assign fall = prev_q & ~sync2_q;
  assign rise = ~prev_q & sync2_q;

  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    db_d        = db_q;
    hold_d      = hold_q;
    rep_d       = rep_q;
    flag_d      = 1'b0;
    key_state_d = key_state_q;
    long_d      = 1'b0;
    rpt_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_FILT_DN;
          db_d    = '0;
        end
      end

      ST_FILT_DN: begin
        // Inside this state the level can only return high through a rising
        // edge, so testing the level is the same as testing for a bounce.
        if (lvl) begin
          state_d = ST_IDLE;
        end else if (db_q == DB_LAST) begin
          state_d     = ST_DOWN;
          flag_d      = 1'b1;
          key_state_d = 1'b0;
          hold_d      = '0;
          rep_d       = '0;
        end else begin
          db_d = db_q + DW'(1);
        end
      end

      ST_DOWN: begin
        // Hold/repeat timing runs on every DOWN cycle, including the cycle
        // that sees a release edge; only FILT_UP cycles are excluded.
        if (hold_q != LONG_SAT) begin
          hold_d = hold_q + HW'(1);
          if (hold_q == LONG_LAST) begin
            long_d = 1'b1;
            rep_d  = '0;
          end
        end else if (REPEAT_CYCLES != 0) begin
          if (rep_q == RPT_LAST) begin
            rpt_d = 1'b1;
            rep_d = '0;
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end

        if (rise) begin
          state_d = ST_FILT_UP;
          db_d    = '0;
        end
      end

      ST_FILT_UP: begin
        // Hold and repeat counters stay frozen here so a release glitch
        // only delays the long/repeat pulses instead of restarting them.
        if (!lvl) begin
          state_d = ST_DOWN;
        end else if (db_q == DB_LAST) begin
          state_d     = ST_IDLE;
          flag_d      = 1'b1;
          key_state_d = 1'b1;
        end else begin
          db_d = db_q + DW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= ST_IDLE;
      db_q        <= '0;
      hold_q      <= '0;
      rep_q       <= '0;
      flag_q      <= 1'b0;
      key_state_q <= 1'b1;
      long_q      <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      db_q        <= db_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      flag_q      <= flag_d;
      key_state_q <= key_state_d;
      long_q      <= long_d;
      rpt_q       <= rpt_d;
    end
  end

  assign key_flag  = flag_q;
  assign key_state = key_state_q;
  assign key_long  = long_q;
  assign key_rpt   = rpt_q;
  assign dbg_state = state_q;

endmodule : key_filter_ch

// File: rtl/key_filter_bank.sv
// ---------------------------------------------------------------------------
// key_filter_bank
// KEY_NUM independent push-button conditioners with long-press and
// auto-repeat detection. Channel i drives bit i of every output bus; there
// is no arbitration, simultaneous events appear in the same cycle.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-low reset
//   key_in    : raw key levels (1 = released, 0 = pressed)
//   key_flag  : per-key one-cycle pulse on accepted press/release
//   key_state : per-key debounced level (1 = released, 0 = pressed)
//   key_long  : per-key one-cycle long-press pulse
//   key_rpt   : per-key one-cycle auto-repeat pulse
//   dbg_state : per-key FSM state, channel i at bits [2*i+1:2*i]
// ---------------------------------------------------------------------------
module key_filter_bank
  import key_filter_pkg::*;
#(
  parameter int          KEY_NUM         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_NUM-1:0]   key_in,
  output logic [KEY_NUM-1:0]   key_flag,
  output logic [KEY_NUM-1:0]   key_state,
  output logic [KEY_NUM-1:0]   key_long,
  output logic [KEY_NUM-1:0]   key_rpt,
  output logic [2*KEY_NUM-1:0] dbg_state
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_st_e ch_state;

    key_filter_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in[i]),
      .key_flag  (key_flag[i]),
      .key_state (key_state[i]),
      .key_long  (key_long[i]),
      .key_rpt   (key_rpt[i]),
      .dbg_state (ch_state)
    );

    assign dbg_state[2*i +: 2] = ch_state;
  end

endmodule : key_filter_bank

// File: tb/tb_key_filter_bank.sv
// ---------------------------------------------------------------------------
// tb_key_filter_bank
// Directed bench for key_filter_bank with DEBOUNCE=16, LONG=64, REPEAT=32 and
// a second instance with REPEAT=0. Inputs are driven 1 ns after a rising
// edge, so the next edge is the first one to sample them ("tick 1"). The
// press flag appears after the edge DEBOUNCE+2 edges later, i.e. on tick
// DEBOUNCE+3 counted from the drive point.
// ---------------------------------------------------------------------------
module tb_key_filter_bank;

  localparam int KN  = 4;
  localparam int DEB = 16;
  localparam int LNG = 64;
  localparam int RPT = 32;
  localparam int LAT = DEB + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [KN-1:0] key_in = '1;

  logic [KN-1:0]   key_flag, key_state, key_long, key_rpt;
  logic [2*KN-1:0] dbg_state;
  logic [KN-1:0]   key_flag_nr, key_state_nr, key_long_nr, key_rpt_nr;
  logic [2*KN-1:0] dbg_state_nr;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  key_filter_bank #(
    .KEY_NUM (KN), .DEBOUNCE_CYCLES (DEB), .LONG_CYCLES (LNG), .REPEAT_CYCLES (RPT)
  ) dut (
    .clk (clk), .rst (rst), .key_in (key_in),
    .key_flag (key_flag), .key_state (key_state), .key_long (key_long),
    .key_rpt (key_rpt), .dbg_state (dbg_state)
  );

  key_filter_bank #(
    .KEY_NUM (KN), .DEBOUNCE_CYCLES (DEB), .LONG_CYCLES (LNG), .REPEAT_CYCLES (0)
  ) dut_nr (
    .clk (clk), .rst (rst), .key_in (key_in),
    .key_flag (key_flag_nr), .key_state (key_state_nr), .key_long (key_long_nr),
    .key_rpt (key_rpt_nr), .dbg_state (dbg_state_nr)
  );

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until key_flag[ch] is seen, or -1 if the limit expires.
  task automatic wait_flag(input int ch, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (key_flag[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_any_flag(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (key_flag != '0) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    key_in = '1;
    repeat (3) tick();
    total++;
    if (key_state !== 4'hF) begin
      bad++; $display("FAIL reset_state got=%b exp=1111", key_state);
    end
    total++;
    if ({key_flag, key_long, key_rpt} !== 12'h000) begin
      bad++; $display("FAIL reset_pulses got=%b exp=0", {key_flag, key_long, key_rpt});
    end
    total++;
    if (dbg_state !== 8'h00) begin
      bad++; $display("FAIL reset_fsm got=%h exp=00", dbg_state);
    end
    rst = 1'b1;
    repeat (5) tick();
    total++;
    if (key_state !== 4'hF || key_flag !== 4'h0) begin
      bad++; $display("FAIL post_reset_idle got state=%b flag=%b exp 1111/0000", key_state, key_flag);
    end
  endtask

  task automatic test_clean_press();
    int n;
    int extra;
    extra = 0;
    key_in[0] = 1'b0;
    wait_flag(0, 40, n);
    total++;
    if (n !== LAT) begin
      bad++; $display("FAIL press_latency got=%0d exp=%0d", n, LAT);
    end
    total++;
    if (key_flag !== 4'b0001 || key_state !== 4'b1110) begin
      bad++; $display("FAIL press_outputs got flag=%b state=%b exp 0001/1110", key_flag, key_state);
    end
    tick();
    total++;
    if (key_flag !== 4'b0000) begin
      bad++; $display("FAIL press_one_cycle got=%b exp=0000", key_flag);
    end
    for (int i = 0; i < 200 - LAT - 1; i++) begin
      tick();
      if (key_flag[0]) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL hold_no_flag got=%0d exp=0", extra);
    end
    key_in[0] = 1'b1;
    wait_flag(0, 40, n);
    total++;
    if (n !== LAT) begin
      bad++; $display("FAIL release_latency got=%0d exp=%0d", n, LAT);
    end
    total++;
    if (key_state !== 4'hF) begin
      bad++; $display("FAIL release_state got=%b exp=1111", key_state);
    end
    repeat (10) tick();
  endtask

  task automatic test_bounce();
    int flags;
    int st_err;
    int n;
    // Bounce ending high: runs of 1..15 cycles never complete a debounce.
    flags = 0;
    st_err = 0;
    for (int s = 0; s < 50; s++) begin
      key_in[2] = (s % 2 == 0) ? 1'b0 : 1'b1;
      repeat ($urandom_range(1, 15)) begin
        tick();
        if (key_flag[2]) flags++;
        if (key_state[2] !== 1'b1) st_err++;
      end
    end
    repeat (40) begin
      tick();
      if (key_flag[2]) flags++;
      if (key_state[2] !== 1'b1) st_err++;
    end
    total++;
    if (flags !== 0) begin
      bad++; $display("FAIL bounce_high_flags got=%0d exp=0", flags);
    end
    total++;
    if (st_err !== 0) begin
      bad++; $display("FAIL bounce_high_state got=%0d bad cycles exp=0", st_err);
    end
    // Bounce ending low and then held: exactly one press is reported.
    flags = 0;
    for (int s = 0; s < 50; s++) begin
      key_in[2] = (s % 2 == 0) ? 1'b1 : 1'b0;
      repeat ($urandom_range(1, 15)) begin
        tick();
        if (key_flag[2]) flags++;
      end
    end
    repeat (LAT + 20) begin
      tick();
      if (key_flag[2]) flags++;
    end
    total++;
    if (flags !== 1) begin
      bad++; $display("FAIL bounce_low_flags got=%0d exp=1", flags);
    end
    total++;
    if (key_state[2] !== 1'b0) begin
      bad++; $display("FAIL bounce_low_state got=%b exp=0", key_state[2]);
    end
    key_in[2] = 1'b1;
    wait_flag(2, 40, n);
    total++;
    if (n !== LAT) begin
      bad++; $display("FAIL bounce_release got=%0d exp=%0d", n, LAT);
    end
    repeat (10) tick();
  endtask

  task automatic test_long_repeat();
    int n;
    int longs[$];
    int rpts[$];
    int longs_nr[$];
    int rpt_nr;
    int after;
    int rel_flags;
    rpt_nr = 0;
    after = 0;
    rel_flags = 0;
    key_in[1] = 1'b0;
    wait_flag(1, 40, n);
    total++;
    if (n !== LAT) begin
      bad++; $display("FAIL long_press_latency got=%0d exp=%0d", n, LAT);
    end
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (key_long[1]) longs.push_back(t);
      if (key_rpt[1]) rpts.push_back(t);
      if (key_long_nr[1]) longs_nr.push_back(t);
      if (key_rpt_nr != '0) rpt_nr++;
    end
    total++;
    if (longs.size() !== 1 || longs[0] !== LNG) begin
      bad++; $display("FAIL long_time got count=%0d first=%0d exp 1 at %0d",
                      longs.size(), (longs.size() > 0) ? longs[0] : -1, LNG);
    end
    total++;
    if (rpts.size() !== 4) begin
      bad++; $display("FAIL rpt_count got=%0d exp=4", rpts.size());
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= rpts.size() || rpts[k] !== LNG + RPT * (k + 1)) begin
        bad++; $display("FAIL rpt_time_%0d got=%0d exp=%0d", k,
                        (k < rpts.size()) ? rpts[k] : -1, LNG + RPT * (k + 1));
      end
    end
    total++;
    if (longs_nr.size() !== 1 || longs_nr[0] !== LNG) begin
      bad++; $display("FAIL norpt_long got count=%0d exp 1 at %0d", longs_nr.size(), LNG);
    end
    total++;
    if (rpt_nr !== 0) begin
      bad++; $display("FAIL norpt_rpt got=%0d exp=0", rpt_nr);
    end
    key_in[1] = 1'b1;
    repeat (40) begin
      tick();
      if (key_long[1] || key_rpt[1]) after++;
      if (key_flag[1]) rel_flags++;
    end
    total++;
    if (after !== 0) begin
      bad++; $display("FAIL pulses_after_release got=%0d exp=0", after);
    end
    total++;
    if (rel_flags !== 1 || key_state[1] !== 1'b1) begin
      bad++; $display("FAIL long_release got flags=%0d state=%b exp 1/1", rel_flags, key_state[1]);
    end
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    int n;
    int flags;
    int st_err;
    int long_t;
    int rpt_t;
    flags = 0;
    st_err = 0;
    long_t = -1;
    rpt_t = -1;
    key_in[1] = 1'b0;
    wait_flag(1, 40, n);
    for (int t = 1; t <= 110; t++) begin
      tick();
      if (key_flag[1]) flags++;
      if (key_state[1] !== 1'b0) st_err++;
      if (key_long[1] && long_t < 0) long_t = t;
      if (key_rpt[1] && rpt_t < 0) rpt_t = t;
      // High for five sampled cycles: ticks 11..15.
      if (t == 10) key_in[1] = 1'b1;
      if (t == 15) key_in[1] = 1'b0;
    end
    total++;
    if (flags !== 0 || st_err !== 0) begin
      bad++; $display("FAIL glitch_no_flag got flags=%0d state_err=%0d exp 0/0", flags, st_err);
    end
    total++;
    if (long_t !== LNG + 5) begin
      bad++; $display("FAIL glitch_long_time got=%0d exp=%0d", long_t, LNG + 5);
    end
    total++;
    if (rpt_t !== LNG + 5 + RPT) begin
      bad++; $display("FAIL glitch_rpt_time got=%0d exp=%0d", rpt_t, LNG + 5 + RPT);
    end
    key_in[1] = 1'b1;
    wait_flag(1, 40, n);
    total++;
    if (n !== LAT) begin
      bad++; $display("FAIL glitch_release got=%0d exp=%0d", n, LAT);
    end
    repeat (10) tick();
  endtask

  task automatic test_multi();
    int n;
    key_in = 4'b0110;
    wait_any_flag(40, n);
    total++;
    if (n !== LAT || key_flag !== 4'b1001) begin
      bad++; $display("FAIL multi_press got t=%0d flag=%b exp t=%0d flag=1001", n, key_flag, LAT);
    end
    total++;
    if (key_state !== 4'b0110) begin
      bad++; $display("FAIL multi_state got=%b exp=0110", key_state);
    end
    tick();
    total++;
    if (key_flag !== 4'b0000) begin
      bad++; $display("FAIL multi_one_cycle got=%b exp=0000", key_flag);
    end
    key_in = 4'b1111;
    wait_any_flag(40, n);
    total++;
    if (n !== LAT || key_flag !== 4'b1001 || key_state !== 4'hF) begin
      bad++; $display("FAIL multi_release got t=%0d flag=%b state=%b exp t=%0d 1001/1111",
                      n, key_flag, key_state, LAT);
    end
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int pulses;
    pulses = 0;
    key_in[2] = 1'b0;
    wait_flag(2, 40, n);
    repeat (5) tick();
    total++;
    if (dbg_state[5:4] !== 2'd2) begin
      bad++; $display("FAIL mid_down_fsm got=%0d exp=2", dbg_state[5:4]);
    end
    rst = 1'b0;
    #1;
    total++;
    if (key_state !== 4'hF || dbg_state !== 8'h00) begin
      bad++; $display("FAIL mid_reset_async got state=%b fsm=%h exp 1111/00", key_state, dbg_state);
    end
    repeat (3) begin
      tick();
      if ({key_flag, key_long, key_rpt} != '0) pulses++;
    end
    total++;
    if (pulses !== 0 || key_state !== 4'hF) begin
      bad++; $display("FAIL mid_reset_hold got pulses=%0d state=%b exp 0/1111", pulses, key_state);
    end
    rst = 1'b1;
    wait_flag(2, 40, n);
    total++;
    if (n !== LAT || key_state !== 4'b1011) begin
      bad++; $display("FAIL reset_rearm got t=%0d state=%b exp t=%0d 1011", n, key_state, LAT);
    end
    key_in[2] = 1'b1;
    wait_flag(2, 40, n);
    total++;
    if (n !== LAT) begin
      bad++; $display("FAIL rearm_release got=%0d exp=%0d", n, LAT);
    end
    repeat (5) tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #5;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_glitch();
    test_multi();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_key_filter_bank
